// File: rtl/key_input_pio.sv
// rtl/key_input_pio.sv - debounced key/switch input port with sticky edge capture and level irq
module key_input_pio #(
    parameter int                WIDTH           = 4,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter int                EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0]  IDLE_VALUE      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] read_sel;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;

    // Upper write-data bits have no storage behind them when WIDTH < 32.
    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    // Two-flop synchroniser; resets to the idle level so no edge appears on reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE_VALUE;
            sync2 <= IDLE_VALUE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: a new level must persist DEBOUNCE_CYCLES cycles; any bounce restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= IDLE_VALUE;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Previous copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= IDLE_VALUE;
        end else begin
            prev <= stable;
        end
    end

    assign rise = stable & ~prev;
    assign fall = ~stable & prev;

    // Select which transitions count as events.
    always_comb begin
        edge_event = rise | fall;
        case (EDGE_TYPE)
            0:       edge_event = rise;
            1:       edge_event = fall;
            default: edge_event = rise | fall;
        endcase
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture, write-1-to-clear; a new event in the clearing cycle wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
        end else if (wr_en && address == ADDR_EDGECAP) begin
            edgecapture <= (edgecapture & ~writedata[WIDTH-1:0]) | edge_event;
        end else begin
            edgecapture <= edgecapture | edge_event;
        end
    end

    assign irq = |(edgecapture & irqmask);

    // Combinational read mux, zero-extended; reserved address reads zero.
    always_comb begin
        read_sel = '0;
        case (address)
            ADDR_DATA:    read_sel = stable;
            ADDR_IRQMASK: read_sel = irqmask;
            ADDR_EDGECAP: read_sel = edgecapture;
            default:      read_sel = '0;
        endcase
        readdata               = '0;
        readdata[WIDTH-1:0]    = read_sel;
    end

endmodule

// File: tb/tb_key_input_pio.sv
// tb/tb_key_input_pio.sv - directed self-checking bench for key_input_pio
module tb_key_input_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int passed = 0;

    key_input_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (1),
        .IDLE_VALUE      (4'hF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        #1;
        check(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        // 1: reset state
        tick(3);
        rd(2'd0, 32'h0000000F, "rst_data");
        chk_irq(1'b0, "rst_irq_in_reset");
        reset_n = 1'b1;
        tick(3);
        rd(2'd0, 32'h0000000F, "post_rst_data");
        rd(2'd1, 32'h0, "post_rst_mask");
        rd(2'd3, 32'h0, "post_rst_edgecap");
        chk_irq(1'b0, "post_rst_irq");

        // 2: bit0 falling step, latency exactly 6 edges
        in_port = 4'hE;
        tick(5);
        rd(2'd0, 32'h0000000F, "step_lat5");
        tick(1);
        rd(2'd0, 32'h0000000E, "step_lat6");
        tick(1);
        rd(2'd3, 32'h1, "step_edgecap");
        chk_irq(1'b0, "step_irq_masked");
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h0, "step_clear");
        in_port = 4'hF;
        tick(8);
        rd(2'd0, 32'h0000000F, "rise_data");
        rd(2'd3, 32'h0, "rise_not_captured");

        // 3: bit1 bouncing low for 3 cycles never qualifies
        for (int p = 0; p < 5; p++) begin
            in_port = 4'hD;
            tick(3);
            in_port = 4'hF;
            tick(3);
            rd(2'd0, 32'h0000000F, "bounce_data");
        end
        tick(8);
        rd(2'd0, 32'h0000000F, "bounce_final_data");
        rd(2'd3, 32'h0, "bounce_edgecap");

        // 4: irq with mask enabled, cleared by write-1
        wr(2'd1, 32'h1);
        rd(2'd1, 32'h1, "mask_readback");
        in_port = 4'hE;
        tick(6);
        chk_irq(1'b0, "irq_before_capture");
        tick(1);
        chk_irq(1'b1, "irq_asserted");
        wr(2'd3, 32'h1);
        chk_irq(1'b0, "irq_cleared_next_cycle");
        in_port = 4'hF;
        tick(8);
        wr(2'd1, 32'h0);
        in_port = 4'hE;
        tick(7);
        rd(2'd3, 32'h1, "masked_edgecap");
        chk_irq(1'b0, "masked_irq");

        // 5: clear of all bits coincides with bit2 event; set wins, bit0 cleared
        in_port = 4'hA;
        tick(6);
        wr(2'd3, 32'hF);
        rd(2'd3, 32'h4, "set_wins");
        rd(2'd0, 32'h0000000A, "set_wins_data");
        wr(2'd3, 32'h4);
        rd(2'd3, 32'h0, "set_wins_cleared");
        in_port = 4'hF;
        tick(8);
        rd(2'd0, 32'h0000000F, "restore_data");

        // 6: reset mid-debounce, then requalification
        wr(2'd1, 32'hF);
        in_port = 4'h7;
        tick(4);
        reset_n = 1'b0;
        rd(2'd0, 32'h0000000F, "midrst_async_data");
        tick(1);
        reset_n = 1'b1;
        rd(2'd0, 32'h0000000F, "midrst_data");
        rd(2'd1, 32'h0, "midrst_mask");
        rd(2'd3, 32'h0, "midrst_edgecap");
        tick(5);
        rd(2'd0, 32'h0000000F, "requal_lat5");
        tick(1);
        rd(2'd0, 32'h00000007, "requal_lat6");
        tick(1);
        rd(2'd3, 32'h8, "requal_edgecap");

        // writes to data and reserved addresses are ignored; upper bits read zero
        wr(2'd0, 32'h0);
        wr(2'd2, 32'hFFFFFFFF);
        rd(2'd0, 32'h00000007, "ign_data");
        rd(2'd1, 32'h0, "ign_mask");
        rd(2'd2, 32'h0, "ign_reserved");
        rd(2'd3, 32'h8, "ign_edgecap");
        wr(2'd1, 32'hFFFFFFF0);
        rd(2'd1, 32'h0, "mask_upper_only");
        chk_irq(1'b0, "mask_upper_irq");
        wr(2'd1, 32'hFFFFFFFF);
        rd(2'd1, 32'h0000000F, "mask_zero_ext");
        chk_irq(1'b1, "mask_all_irq");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
